// File: rtl/rv_alu_pkg.sv
// Shared opcode encoding and width constants for the RV32I ALU.
// No logic, no latency, no backpressure.
package rv_alu_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b0110,
        ALU_XOR  = 4'b1000,
        ALU_OR   = 4'b1001,
        ALU_AND  = 4'b1010
    } alu_op_e;

endpackage

// File: rtl/rv_alu_shifter.sv
// Five-stage log barrel shifter shared by SLL/SRL/SRA.
// Combinational, zero latency; no backpressure.
module rv_alu_shifter
    import rv_alu_pkg::*;
(
    input  logic [XLEN-1:0]    i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic               i_left,
    input  logic               i_arith,
    output logic [XLEN-1:0]    o_data
);

    logic [XLEN-1:0] w_stage [0:SHAMT_W];
    logic [XLEN-1:0] w_right;
    logic            w_fill;

    // Left shifts reuse the right-shift stages by bit-reversing in and out.
    always_comb begin
        for (int i = 0; i < XLEN; i++) begin
            w_stage[0][i] = i_left ? i_data[XLEN-1-i] : i_data[i];
        end
    end

    assign w_fill = i_arith & ~i_left & i_data[XLEN-1];

    for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
        assign w_stage[s+1] = i_shamt[s]
                            ? {{(1 << s){w_fill}}, w_stage[s][XLEN-1:(1 << s)]}
                            : w_stage[s];
    end

    assign w_right = w_stage[SHAMT_W];

    always_comb begin
        for (int i = 0; i < XLEN; i++) begin
            o_data[i] = i_left ? w_right[XLEN-1-i] : w_right[i];
        end
    end

endmodule

// File: rtl/rv_alu.sv
// RV32I execute-stage ALU: combinational result plus a one-cycle registered copy.
// o_alu_data has zero latency, o_alu_data_q one cycle; no handshake or backpressure.
module rv_alu
    import rv_alu_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic [3:0]      i_alu_op,
    output logic [XLEN-1:0] o_alu_data,
    output logic [XLEN-1:0] o_alu_data_q
);

    logic [XLEN-1:0] w_sum;
    logic [XLEN:0]   w_diff;
    logic            w_ovf;
    logic            w_slt;
    logic            w_sltu;
    logic [XLEN-1:0] w_shift;
    logic            w_sh_left;
    logic            w_sh_arith;
    logic [XLEN-1:0] w_result;
    logic [XLEN-1:0] r_alu_data_q;

    assign w_sum  = i_op_a + i_op_b;

    // One zero-extended subtraction yields SUB, the unsigned borrow and the signed compare.
    assign w_diff = {1'b0, i_op_a} - {1'b0, i_op_b};
    assign w_sltu = w_diff[XLEN];
    assign w_ovf  = (i_op_a[XLEN-1] ^ i_op_b[XLEN-1]) & (i_op_a[XLEN-1] ^ w_diff[XLEN-1]);
    assign w_slt  = w_diff[XLEN-1] ^ w_ovf;

    assign w_sh_left  = (i_alu_op == ALU_SLL);
    assign w_sh_arith = (i_alu_op == ALU_SRA);

    rv_alu_shifter u_shifter (
        .i_data  (i_op_a),
        .i_shamt (i_op_b[SHAMT_W-1:0]),
        .i_left  (w_sh_left),
        .i_arith (w_sh_arith),
        .o_data  (w_shift)
    );

    always_comb begin
        w_result = '0;
        case (alu_op_e'(i_alu_op))
            ALU_ADD:  w_result = w_sum;
            ALU_SUB:  w_result = w_diff[XLEN-1:0];
            ALU_SLT:  w_result = {{(XLEN-1){1'b0}}, w_slt};
            ALU_SLTU: w_result = {{(XLEN-1){1'b0}}, w_sltu};
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  w_result = w_shift;
            ALU_XOR:  w_result = i_op_a ^ i_op_b;
            ALU_OR:   w_result = i_op_a | i_op_b;
            ALU_AND:  w_result = i_op_a & i_op_b;
            default:  w_result = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_alu_data_q <= '0;
        end else begin
            r_alu_data_q <= w_result;
        end
    end

    assign o_alu_data   = w_result;
    assign o_alu_data_q = r_alu_data_q;

endmodule

// File: tb/tb_rv_alu.sv
// Scoreboard bench for rv_alu: directed vectors push expected results, a monitor pops and compares.
module tb_rv_alu;
    import rv_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [3:0]  alu_op = 4'b0000;
    logic [31:0] alu_data;
    logic [31:0] alu_data_q;

    always #5 clk = ~clk;

    rv_alu dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_op_a       (op_a),
        .i_op_b       (op_b),
        .i_alu_op     (alu_op),
        .o_alu_data   (alu_data),
        .o_alu_data_q (alu_data_q)
    );

    typedef struct {
        logic [31:0] exp;
        int          stamp;
        string       name;
    } exp_t;

    exp_t q_comb[$];
    exp_t q_reg[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: comb result checked the same cycle, registered result once an edge has passed.
    always @(negedge clk) begin
        exp_t e;
        if (q_reg.size() > 0 && q_reg[0].stamp < cyc) begin
            e = q_reg.pop_front();
            check({e.name, "/q"}, alu_data_q, e.exp);
        end
        if (q_comb.size() > 0) begin
            e = q_comb.pop_front();
            check(e.name, alu_data, e.exp);
        end
    end

    task automatic apply(input string nm, input logic [3:0] op, input int a, input int b,
                         input int exp, input bit rst_rel);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n  = rst_rel;
        alu_op = op;
        op_a   = a;
        op_b   = b;
        e.exp   = exp;
        e.stamp = cyc;
        e.name  = nm;
        q_comb.push_back(e);
        e.exp   = rst_rel ? exp : 32'h0;
        q_reg.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for two edges while the combinational path keeps tracking.
        apply("rst_add0", ALU_ADD, 1, 2, 3, 1'b0);
        apply("rst_xor1", ALU_XOR, 32'h0000_00F0, 32'h0000_0FF0, 32'h0000_0F00, 1'b0);

        apply("add_pos",   ALU_ADD, 3232453, 4995, 3237448, 1'b1);
        apply("add_neg",   ALU_ADD, -3232453, -435995, -3668448, 1'b1);
        apply("sub_mix",   ALU_SUB, 343735889, -392837334, 736573223, 1'b1);
        apply("add_wrap",  ALU_ADD, 32'hFFFF_FFFF, 1, 0, 1'b1);
        apply("xor",       ALU_XOR, 104566398, 4513346, 32'h067F_503C, 1'b1);
        apply("or",        ALU_OR,  12398, 45, 12399, 1'b1);
        apply("and",       ALU_AND, 1800000032, 1283744400, 32'h4800_4200, 1'b1);

        apply("sll_10",    ALU_SLL, 49, 10, 50176, 1'b1);
        apply("sll_31",    ALU_SLL, 1, 31, 32'h8000_0000, 1'b1);
        apply("sll_hib",   ALU_SLL, 1, 32'hFFFF_FFE4, 32'h0000_0010, 1'b1);
        apply("srl_12",    ALU_SRL, 112033, 12, 27, 1'b1);
        apply("srl_hib",   ALU_SRL, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1'b1);
        apply("sra_27",    ALU_SRA, -445060133, 27, 32'hFFFF_FFFC, 1'b1);
        apply("sra_sh0",   ALU_SRA, 32'h8000_0001, 32'h0000_0020, 32'h8000_0001, 1'b1);
        apply("sra_pos",   ALU_SRA, 32'h7000_0000, 4, 32'h0700_0000, 1'b1);

        // Mid-stream reset: only the registered copy is cleared.
        apply("rst_mid",   ALU_ADD, 10, 20, 30, 1'b0);

        apply("sltu_nn",   ALU_SLTU, -250032, -40010, 1, 1'b1);
        apply("sltu_np",   ALU_SLTU, -18930002, 102847, 0, 1'b1);
        apply("slt_nn",    ALU_SLT, -25002, -43000, 0, 1'b1);
        apply("slt_np",    ALU_SLT, -18930002, 1028472, 1, 1'b1);
        apply("slt_pn",    ALU_SLT, 75834440, -28334000, 0, 1'b1);
        apply("slt_min",   ALU_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 1, 1'b1);
        apply("sltu_min",  ALU_SLTU, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1'b1);
        apply("slt_max",   ALU_SLT,  32'h7FFF_FFFF, 32'h8000_0000, 0, 1'b1);
        apply("sltu_max",  ALU_SLTU, 32'h7FFF_FFFF, 32'h8000_0000, 1, 1'b1);
        apply("slt_eq",    ALU_SLT, -7, -7, 0, 1'b1);

        apply("inv_7",     4'b0111, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1'b1);
        for (int op = 11; op < 16; op++) begin
            apply($sformatf("inv_%0d", op), 4'(op), 32'hDEAD_BEEF, 32'h1234_5678, 0, 1'b1);
        end
        apply("tail_sub",  ALU_SUB, 5, 7, -2, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (q_comb.size() != 0 || q_reg.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d/%0d entries left, expected 0/0", q_comb.size(), q_reg.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv_alu.md
Name: rv_alu

Overview:
- 32-bit integer ALU for the RV32I execute stage.
- Performs add/sub, signed and unsigned set-less-than, shifts, and bitwise logic, selected by a 4-bit opcode from the decoder.
- Result is combinational (zero latency) for same-cycle use by branch, writeback and forwarding logic.
- A registered copy of the result is also provided for the pipeline register, clocked by the single core clock.

Parameters:
- XLEN, 32, operand/result width. Only 32 is required to be supported.
- SHAMT_W, 5, shift-amount width, equal to log2(XLEN).

Ports:
- i_clk  input  1  core clock; rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_op_a  input  32  operand A (rs1 or PC).
- i_op_b  input  32  operand B (rs2 or immediate).
- i_alu_op  input  4  operation select.
- o_alu_data  output  32  combinational result.
- o_alu_data_q  output  32  result registered on the rising edge of i_clk.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (i_clk, i_rst_n).
- Opcode encoding and the value driven on o_alu_data:
  - 0000 ADD: A+B, modulo 2^32, no carry or overflow output.
  - 0001 SUB: A-B, modulo 2^32.
  - 0010 SLT: 1 if $signed(A) < $signed(B), else 0, zero-extended to 32 bits.
  - 0011 SLTU: 1 if A < B as unsigned, else 0, zero-extended.
  - 0100 SLL: A << B[4:0], zero fill.
  - 0101 SRL: A >> B[4:0], zero fill.
  - 0110 SRA: A >>> B[4:0], fill with A[31].
  - 1000 XOR: A ^ B.
  - 1001 OR: A | B.
  - 1010 AND: A & B.
  - All other codes (0111, 1011-1111): result 32'h0.
- Shifts use only B[4:0]; B[31:5] is ignored. A shift amount of 0 returns A unchanged.
- SLT and SLTU are derived from one 33-bit subtraction (A - B with the operands extended):
  - SLTU = borrow.
  - SLT = sign of result XOR signed overflow.
  - Both must match the mathematical comparison for all values, including 0x80000000 and 0x7FFFFFFF.
- o_alu_data is purely combinational from i_op_a, i_op_b and i_alu_op. It is independent of i_clk and i_rst_n. There are no latches.
- o_alu_data_q:
  - On a rising edge of i_clk with i_rst_n=0, loads 32'h0.
  - Otherwise, on every rising edge, loads o_alu_data.
  - Latency is one cycle; there is no enable and no handshake.
- Reset mid-operation affects only o_alu_data_q; o_alu_data keeps tracking its inputs.
- After power-up, o_alu_data_q is undefined until the first reset edge.

Decomposition:
- Shared package rv_alu_pkg holds:
  - typedef enum logic [3:0] alu_op_e with the ten opcodes above.
  - Constants XLEN=32 and SHAMT_W=5.
- One sub-module, rv_alu_shifter: a 5-stage log barrel shifter.
  - Inputs: data, shamt, and direction plus arithmetic selects.
  - Output: shifted data.
  - Handles SLL, SRL and SRA in one shared structure.
- Adder/subtractor and logic operations stay inline in rv_alu.

Test Plan:
- Arithmetic:
  - ADD A=3232453, B=4995 -> 3237448.
  - ADD A=-3232453, B=-435995 -> -3668448.
  - SUB A=343735889, B=-392837334 -> 736573223.
  - ADD 0xFFFFFFFF+1 -> 0 (wrap).
- Logic:
  - XOR 104566398 ^ 4513346 -> bitwise XOR.
  - OR 12398 | 45 -> 12399.
  - AND 1800000032 & 1283744400 -> bitwise AND.
  - Each checked against a reference model value.
- Shifts:
  - SLL 49 by 10 -> 50176.
  - SRL 112033 by 12 -> 27.
  - SRA -445060133 by 27 -> 0xFFFFFFFC.
  - SRL 0x80000000 with B=0x00000021 -> shift by 1 -> 0x40000000.
- Compares:
  - SLTU (-250032, -40010) -> 1.
  - SLTU (-18930002, 102847) -> 0.
  - SLT (-25002, -43000) -> 0.
  - SLT (-18930002, 1028472) -> 1.
  - SLT (75834440, -28334000) -> 0.
  - SLT (0x80000000, 0x7FFFFFFF) -> 1; SLTU on the same operands -> 0.
- Invalid opcodes: 0111 and 1011..1111 with nonzero operands -> o_alu_data = 0.
- Register and reset:
  - Hold i_rst_n=0 for 2 edges -> o_alu_data_q = 0 while o_alu_data still tracks inputs.
  - Release reset -> o_alu_data_q equals the previous cycle's o_alu_data on every edge.
  - Assert reset mid-stream -> o_alu_data_q = 0 at the next edge.
